// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that assembles two-byte command frames (operand byte, then opcode byte)
// and presents them through a valid/ready handshake, flagging framing, protocol and overrun errors.
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] operands,
    output logic [2:0] opcode,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       cmd_err,
    output logic       overrun
);

    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic {
        ASM_EMPTY,
        ASM_HAVE_OPS
    } asm_state_e;

    logic             rx_meta_q;
    logic             rx_s_q;
    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shreg_q;
    logic             frame_err_q;

    asm_state_e       asm_state_q;
    logic [7:0]       ops_hold_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             cmd_err_q;

    logic [7:0]       operands_q, operands_d;
    logic [2:0]       opcode_q, opcode_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             overrun_q, overrun_d;

    logic             bit_tick;
    logic             byte_done;
    logic             stop_bad;
    logic             bad_opcode;
    logic             timeout;
    logic             emit;

    assign bit_tick   = (clk_cnt_q == LAST_TICK);
    assign byte_done  = (rx_state_q == RX_STOP) && bit_tick && rx_s_q;
    assign stop_bad   = (rx_state_q == RX_STOP) && bit_tick && !rx_s_q;
    assign bad_opcode = |shreg_q[7:3];
    assign timeout    = (asm_state_q == ASM_HAVE_OPS) && (rx_state_q == RX_IDLE)
                        && (to_cnt_q == TO_LAST);
    assign emit       = (asm_state_q == ASM_HAVE_OPS) && byte_done && !bad_opcode;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_state_q  <= RX_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            case (rx_state_q)
                RX_IDLE: begin
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_s_q) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (clk_cnt_q == HALF_TICK) begin
                        clk_cnt_q  <= '0;
                        rx_state_q <= rx_s_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_tick) begin
                        clk_cnt_q <= '0;
                        shreg_q   <= {rx_s_q, shreg_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_tick) begin
                        clk_cnt_q  <= '0;
                        rx_state_q <= rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s_q) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Frame assembler: holds the operand byte and watches the inter-byte gap.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            asm_state_q <= ASM_EMPTY;
            ops_hold_q  <= '0;
            to_cnt_q    <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            if (stop_bad) begin
                asm_state_q <= ASM_EMPTY;
            end else begin
                case (asm_state_q)
                    ASM_EMPTY: begin
                        if (byte_done) begin
                            ops_hold_q  <= shreg_q;
                            to_cnt_q    <= '0;
                            asm_state_q <= ASM_HAVE_OPS;
                        end
                    end
                    ASM_HAVE_OPS: begin
                        if (byte_done) begin
                            cmd_err_q   <= bad_opcode;
                            asm_state_q <= ASM_EMPTY;
                        end else if (timeout) begin
                            cmd_err_q   <= 1'b1;
                            asm_state_q <= ASM_EMPTY;
                        end else if (rx_state_q == RX_IDLE) begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    default: asm_state_q <= ASM_EMPTY;
                endcase
            end
        end
    end

    // A command accepted this cycle frees the slot for a simultaneous emit.
    always_comb begin
        operands_d  = operands_q;
        opcode_d    = opcode_q;
        cmd_valid_d = cmd_valid_q;
        overrun_d   = 1'b0;
        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
        if (emit) begin
            if (!cmd_valid_q || cmd_ready) begin
                operands_d  = ops_hold_q;
                opcode_d    = shreg_q[2:0];
                cmd_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            operands_q  <= '0;
            opcode_q    <= '0;
            cmd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            operands_q  <= operands_d;
            opcode_q    <= opcode_d;
            cmd_valid_q <= cmd_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign operands  = operands_q;
    assign opcode    = opcode_q;
    assign cmd_valid = cmd_valid_q;
    assign rx_busy   = (rx_state_q != RX_IDLE);
    assign frame_err = frame_err_q;
    assign cmd_err   = cmd_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Serial command receiver that sits directly upstream of the `FSM` core. It deserialises 8N1 UART traffic on one input pin and assembles two-byte command frames: an operand byte followed by an opcode byte. Each complete frame is presented as `{a,b}` operands plus a 3-bit opcode through a valid/ready handshake, in the same format the core takes from `user_input` / `user_io_input[2:0]`. It also flags framing, protocol and overrun errors.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit. Must be ≥ 4; the half-bit point is `CLKS_PER_BIT/2`, truncated.
- `TIMEOUT_BITS`, default 20: bit periods allowed between the end of byte 0 and the start of byte 1.
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `operands`  out  8  `{a[3:0], b[3:0]}` from byte 0.
- `opcode`  out  3  byte 1 bits [2:0].
- `cmd_valid`  out  1  command pending.
- `cmd_ready`  in  1  consumer accepts the command.
- `rx_busy`  out  1  bit receiver not in IDLE.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `cmd_err`  out  1  one-cycle pulse: byte 1 bits [7:3] ≠ 0, or inter-byte timeout.
- `overrun`  out  1  one-cycle pulse: frame completed while `cmd_valid` was already high.

## Operation
- **Input synchroniser:** `rx` passes through two flops before use, giving `rx_s`. Both flops reset to 1.
- **Bit receiver FSM:**
  - IDLE: leave on `rx_s` = 0 → START, bit counter cleared.
  - START: wait `CLKS_PER_BIT/2` cycles, then resample. If `rx_s` = 1 the start was a glitch → IDLE, nothing reported. Otherwise → DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first, shifting into `shreg`. → STOP after bit 7.
  - STOP: sample one `CLKS_PER_BIT` later.
    - `rx_s` = 1: byte complete → IDLE.
    - `rx_s` = 0: pulse `frame_err`, discard the byte, → WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` = 1, then → IDLE. This absorbs line breaks.
- **Frame assembler:**
  - States: EMPTY and HAVE_OPS.
  - EMPTY, byte complete: latch it into `ops_hold` → HAVE_OPS, clear the timeout counter.
  - HAVE_OPS, byte complete:
    - Bits [7:3] ≠ 0: pulse `cmd_err`, drop both bytes → EMPTY.
    - Otherwise emit the command → EMPTY.
  - HAVE_OPS, timeout: the counter increments every cycle while the bit receiver is IDLE. At `TIMEOUT_BITS*CLKS_PER_BIT` counts: pulse `cmd_err` → EMPTY.
  - A `frame_err` in either assembler state returns the assembler to EMPTY.
- **Output handshake:**
  - Emit, with `cmd_valid` = 0: load `operands`/`opcode` and set `cmd_valid`.
  - `cmd_valid` stays high, with outputs stable, until a cycle where `cmd_ready` = 1. `cmd_valid` falls the next cycle.
  - Emit while `cmd_valid` = 1: the new command is dropped, `overrun` pulses, and the held outputs are unchanged.
  - Emit in the same cycle as `cmd_valid && cmd_ready`: the new command is loaded and `cmd_valid` stays high. There is no overrun.
- **Reset values:** `operands` = 0, `opcode` = 0, `cmd_valid` = 0, `rx_busy` = 0, all error pulses 0. Bit FSM = IDLE, assembler = EMPTY, counters = 0.
- **Reset mid-operation:** a reset mid-byte or mid-frame discards all partial data. The pending command is lost.

## Timing
- **Start detection:** falling edge on `rx` → START entered 3 cycles later (2 synchroniser flops plus the state register).
- **Sample points:** each data bit is sampled at its nominal centre ± 1 cycle.
- **Command latency:** `cmd_valid` rises on the cycle after the byte-1 stop-bit sample.
- **Error pulses:** `frame_err` and `cmd_err` are asserted on the cycle after the offending sample or timeout expiry.
- **`rx_busy`:** high from START entry until return to IDLE, inclusive of WAIT_HIGH.
- **Back-to-back bytes:** consecutive bytes with zero idle time are received correctly.

## Test plan
Every scenario below uses `CLKS_PER_BIT` = 8.
- **Basic command:** send 0x35 then 0x02, with `cmd_ready` = 1 → `operands` = 0x35, `opcode` = 3'b010, `cmd_valid` high for exactly 1 cycle. No error pulses.
- **Backpressure and overrun:** hold `cmd_ready` = 0 and send frames (0x12, 0x01) then (0x34, 0x03).
  - First frame: `cmd_valid` stays high with `operands` = 0x12.
  - Second frame: `overrun` pulses once and the outputs are unchanged.
  - Raise `cmd_ready` → `cmd_valid` drops the next cycle.
- **Framing error:** send byte 0xA5 with its stop bit driven low, hold `rx` low for 30 cycles, then release it and send (0x11, 0x04).
  - Required: `frame_err` pulses once, and no command is issued for 0xA5.
  - The following frame then yields `operands` = 0x11, `opcode` = 3'b100.
- **Protocol error and timeout:**
  - Send 0x77 then 0x08 → `cmd_err` pulses and no `cmd_valid`.
  - Send 0x77, then idle for 160 cycles (= 20 bit periods at `CLKS_PER_BIT` = 8) → `cmd_err` pulses.
  - Then send (0x99, 0x05) → `operands` = 0x99, `opcode` = 3'b101.
- **Glitch rejection:** drive a 2-cycle low pulse on `rx` → `rx_busy` rises, returns to IDLE, and no outputs change.
- **Reset mid-frame:** assert `reset_n` = 0 for 1 cycle during bit 4 of byte 1.
  - Required: all outputs return to 0 and the bit FSM goes to IDLE.
  - A subsequent clean frame (0x42, 0x06) is received correctly.
